alu_rs: RTL and testbench
=========================

# alu_rs

Reservation station for the integer ALU. It holds renamed ALU instructions from dispatch until their physical source operands are produced. It wakes entries on writeback broadcasts and issues the oldest ready entry to the single-cycle `alu`, which reads the register file combinationally in the issue cycle. It sits between rename/dispatch and `alu`, and is cleared on pipeline flush.

## Interface

**Parameters**
- `RS_DEPTH`, default 8: number of entries (power of two, at least 2).
- `PHYS_REG_BITS` and `ROB_BITS` come from `ooo_types`; they are not redeclared.

**rs_entry_t fields used:** `valid`, `prs1`, `prs2`, `prs1_ready`, `prs2_ready`, `prd`, `rob_tag`, `alu_op`, `alu_src`, `immediate`, `reg_write`.

**Ports**
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `dispatch_en`  in  1  write `dispatch_entry` this cycle.
- `dispatch_entry`  in  rs_entry_t  renamed instruction; the ready bits reflect the busy table at rename.
- `full`  out  1  count == RS_DEPTH.
- `count`  out  $clog2(RS_DEPTH)+1  number of occupied entries.
- `wb0_en`, `wb0_prd`  in  1, PHYS_REG_BITS  ALU writeback broadcast.
- `wb1_en`, `wb1_prd`  in  1, PHYS_REG_BITS  second-FU (LSU) writeback broadcast.
- `alu_ready`  in  1  ALU accepts an issue this cycle.
- `issue_en`  out  1  `issue_entry` is valid and consumed at this edge.
- `issue_entry`  out  rs_entry_t  selected entry; all zero when `issue_en` = 0.
- `flush`  in  1  synchronous clear of all entries.

## Operation

**Storage**
- Collapsing queue: slot 0 is the oldest entry, and occupied slots are `0..count-1`.
- An entry is ready when `prs1_ready && (prs2_ready || alu_src)`. With `alu_src`=1 the immediate replaces rs2, so `prs2` is don't-care.

**Select**
- The candidate is the lowest-index ready slot.
- `issue_en` = candidate exists && `alu_ready` && !`flush`.
- `issue_entry` is the candidate's stored contents with `valid`=1. Select is combinational from registered state.

**Removal**
- On an issue edge, the issued slot is removed. Slots above it shift down by one, preserving age order.

**Wakeup**
- On each edge, for every occupied slot: if `wbX_en` and `wbX_prd` == `prs1`, set `prs1_ready`; the same applies to `prs2`.
- Both ports are checked in parallel.
- `wb*_prd` = 0 is ignored. Source p0 is always ready; `prs*` = 0 is forced ready at insert.

**Dispatch**
- If `dispatch_en` && !`full` && !`flush`, the entry is appended at slot `count` (or `count-1` when an issue in the same cycle shifts the queue).
- Same-cycle wakeup bypass applies to the incoming entry: a `wb*_prd` matching its `prs*` sets that ready bit at insert.
- Dispatch while `full` is dropped silently. Upstream must stall on `full`; there is no same-cycle credit from a simultaneous issue.

**Count**
- Next count = count + accepted_dispatch − issue_en.

**Flush**
- All `valid` bits are cleared and `count` becomes 0 at the edge.
- `issue_en` is 0 in the flush cycle, and dispatch in the flush cycle is dropped.

**Reset**
- Asynchronously clears all entries, `count`=0, `full`=0, `issue_en`=0, `issue_entry`='0.
- Outputs stay at these values until the first dispatch is accepted.

## Timing

- Dispatch at edge N: the entry is visible from cycle N+1. It can issue in cycle N+1 at the earliest (`issue_en` high before edge N+1), never in its own dispatch cycle.
- Wakeup broadcast in cycle N (sampled at edge N): a dependent entry can issue in cycle N+1, giving back-to-back issue of dependent ALU ops.
- An issue in cycle N frees the slot at edge N. `full` deasserts in cycle N+1.
- `alu_ready`=0 holds all entries. Wakeups still apply while held.
- Simultaneous dispatch, issue and wakeup in one cycle are all honoured, and ordering is preserved.

## Test plan

1. Reset, then dispatch `rob_tag`=0, `prd`=10, both sources ready, `alu_ready`=1. Required: `issue_en`=1 the next cycle with `issue_entry.rob_tag`=0, `prd`=10, and `count` returns 1→0.
2. Dispatch with `prs1`=20 not ready. Required: no issue for 3 cycles; then `wb0_en`=1, `wb0_prd`=20 at edge N gives `issue_en` in cycle N+1. Repeat via `wb1` for `prs2`=21.
3. Dispatch A (`rob` 1, waits on p30), then B (`rob` 2, ready), then C (`rob` 3, ready). Required issue order: 2, then 3. Waking p30 then gives `rob` 1; `count` ends at 0.
4. Dispatch 8 ready entries with `alu_ready`=0. Required: `full`=1, `count`=8, and a 9th dispatch is dropped. Then set `alu_ready`=1: the 8 entries issue in dispatch order over 8 cycles, and `full`=0 after the first issue.
5. Dispatch `prs1`=40 in the same cycle as `wb1_prd`=40. Required: the entry issues in the next cycle. Also, an `alu_src`=1 entry with non-ready `prs2` issues immediately.
6. Hold 5 entries with `alu_ready`=0, then assert `flush` together with `dispatch_en`. Required: `count`=0 and `issue_en`=0 after the edge, the dispatch is dropped, and no issue occurs afterwards. An asynchronous `rst` mid-queue clears the block without waiting for a clock edge.

Source files
------------

// File: rtl/alu_rs.sv
// Integer ALU reservation station: collapsing age-ordered queue with writeback
// wakeup and oldest-ready select. The ooo_types package is carried here so the file stands alone.
package ooo_types;
  localparam int PHYS_REG_BITS = 6;
  localparam int ROB_BITS      = 5;

  typedef struct packed {
    logic                     valid;
    logic [PHYS_REG_BITS-1:0] prs1;
    logic [PHYS_REG_BITS-1:0] prs2;
    logic                     prs1_ready;
    logic                     prs2_ready;
    logic [PHYS_REG_BITS-1:0] prd;
    logic [ROB_BITS-1:0]      rob_tag;
    logic [3:0]               alu_op;
    logic                     alu_src;
    logic [31:0]              immediate;
    logic                     reg_write;
  } rs_entry_t;
endpackage

module alu_rs
  import ooo_types::*;
#(
  parameter int RS_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       dispatch_en,
  input  rs_entry_t                  dispatch_entry,
  output logic                       full,
  output logic [$clog2(RS_DEPTH):0]  count,
  input  logic                       wb0_en,
  input  logic [PHYS_REG_BITS-1:0]   wb0_prd,
  input  logic                       wb1_en,
  input  logic [PHYS_REG_BITS-1:0]   wb1_prd,
  input  logic                       alu_ready,
  output logic                       issue_en,
  output rs_entry_t                  issue_entry,
  input  logic                       flush
);

  localparam int IW = $clog2(RS_DEPTH);
  localparam int CW = IW + 1;

  rs_entry_t               entries_reg [RS_DEPTH];
  rs_entry_t               entries_next [RS_DEPTH];
  logic [CW-1:0]           count_reg;
  logic [CW-1:0]           count_next;
  logic [RS_DEPTH-1:0]     ready_vec;
  logic [RS_DEPTH-1:0]     shift_vec;
  logic [RS_DEPTH-1:0]     ins_vec;
  logic [IW-1:0]           sel_idx;
  logic                    found;
  logic                    disp_acc;
  logic [CW-1:0]           ins_pos;
  rs_entry_t               disp_woken;

  // Physical register 0 is never broadcast as a real producer.
  function automatic rs_entry_t wake(input rs_entry_t e,
                                     input logic w0, input logic [PHYS_REG_BITS-1:0] p0,
                                     input logic w1, input logic [PHYS_REG_BITS-1:0] p1);
    rs_entry_t r;
    logic h0, h1;
    r  = e;
    h0 = w0 && (p0 != '0);
    h1 = w1 && (p1 != '0);
    if ((h0 && p0 == e.prs1) || (h1 && p1 == e.prs1)) r.prs1_ready = 1'b1;
    if ((h0 && p0 == e.prs2) || (h1 && p1 == e.prs2)) r.prs2_ready = 1'b1;
    return r;
  endfunction

  assign full  = (count_reg == CW'(RS_DEPTH));
  assign count = count_reg;

  // Oldest-first select: scanning downward leaves the lowest ready index.
  always_comb begin
    found   = 1'b0;
    sel_idx = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (ready_vec[i]) begin
        found   = 1'b1;
        sel_idx = IW'(i);
      end
    end
  end

  assign issue_en = found && alu_ready && !flush;

  always_comb begin
    issue_entry = '0;
    if (issue_en) begin
      issue_entry       = entries_reg[sel_idx];
      issue_entry.valid = 1'b1;
    end
  end

  assign disp_acc   = dispatch_en && !full && !flush;
  assign ins_pos    = count_reg - CW'(issue_en);
  assign shift_vec  = issue_en ? ~((RS_DEPTH'(1) << sel_idx) - RS_DEPTH'(1)) : '0;
  assign ins_vec    = disp_acc ? (RS_DEPTH'(1) << ins_pos) : '0;
  assign count_next = count_reg + CW'(disp_acc) - CW'(issue_en);

  always_comb begin
    disp_woken       = wake(dispatch_entry, wb0_en, wb0_prd, wb1_en, wb1_prd);
    disp_woken.valid = 1'b1;
    if (dispatch_entry.prs1 == '0) disp_woken.prs1_ready = 1'b1;
    if (dispatch_entry.prs2 == '0) disp_woken.prs2_ready = 1'b1;
  end

  genvar gi;
  generate
    for (gi = 0; gi < RS_DEPTH; gi++) begin : g_slot
      rs_entry_t upper;
      rs_entry_t src;

      if (gi < RS_DEPTH - 1) begin : g_up
        assign upper = entries_reg[gi+1];
      end else begin : g_top
        assign upper = '0;
      end

      assign ready_vec[gi] = entries_reg[gi].valid && entries_reg[gi].prs1_ready &&
                             (entries_reg[gi].prs2_ready || entries_reg[gi].alu_src);

      always_comb begin
        src = shift_vec[gi] ? upper : entries_reg[gi];
        if (ins_vec[gi]) entries_next[gi] = disp_woken;
        else             entries_next[gi] = wake(src, wb0_en, wb0_prd, wb1_en, wb1_prd);
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
      for (int i = 0; i < RS_DEPTH; i++) entries_reg[i] <= '0;
    end else if (flush) begin
      count_reg <= '0;
      for (int i = 0; i < RS_DEPTH; i++) entries_reg[i] <= '0;
    end else begin
      count_reg <= count_next;
      for (int i = 0; i < RS_DEPTH; i++) entries_reg[i] <= entries_next[i];
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// Directed bench for alu_rs: each step drives inputs, then compares outputs
// against hand-computed values with immediate assertions.
module tb_alu_rs;
  import ooo_types::*;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     dispatch_en;
  rs_entry_t                dispatch_entry;
  logic                     full;
  logic [3:0]               count;
  logic                     wb0_en, wb1_en;
  logic [PHYS_REG_BITS-1:0] wb0_prd, wb1_prd;
  logic                     alu_ready;
  logic                     issue_en;
  rs_entry_t                issue_entry;
  logic                     flush;

  int vectors    = 0;
  int miscompares = 0;

  alu_rs #(.RS_DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .dispatch_en(dispatch_en), .dispatch_entry(dispatch_entry),
    .full(full), .count(count),
    .wb0_en(wb0_en), .wb0_prd(wb0_prd),
    .wb1_en(wb1_en), .wb1_prd(wb1_prd),
    .alu_ready(alu_ready), .issue_en(issue_en), .issue_entry(issue_entry),
    .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_issue(input string tag, input int rob);
    chk({tag, ".issue_en"}, 64'(issue_en), 64'd1);
    chk({tag, ".rob_tag"}, 64'(issue_entry.rob_tag), 64'(rob));
    chk({tag, ".valid"}, 64'(issue_entry.valid), 64'd1);
    $display("issue %s rob=%0d prd=%0d", tag, issue_entry.rob_tag, issue_entry.prd);
  endtask

  function automatic rs_entry_t mk(input int rob, input int prd,
                                   input int p1, input logic r1,
                                   input int p2, input logic r2, input logic src);
    rs_entry_t e;
    e            = '0;
    e.valid      = 1'b1;
    e.rob_tag    = ROB_BITS'(rob);
    e.prd        = PHYS_REG_BITS'(prd);
    e.prs1       = PHYS_REG_BITS'(p1);
    e.prs1_ready = r1;
    e.prs2       = PHYS_REG_BITS'(p2);
    e.prs2_ready = r2;
    e.alu_src    = src;
    e.alu_op     = 4'h3;
    e.immediate  = 32'h1234 + 32'(rob);
    e.reg_write  = 1'b1;
    return e;
  endfunction

  task automatic disp(input rs_entry_t e);
    dispatch_entry = e;
    dispatch_en    = 1'b1;
    tick();
    dispatch_en    = 1'b0;
    dispatch_entry = '0;
  endtask

  initial begin
    rst = 1'b1; dispatch_en = 1'b0; dispatch_entry = '0;
    wb0_en = 1'b0; wb0_prd = '0; wb1_en = 1'b0; wb1_prd = '0;
    alu_ready = 1'b0; flush = 1'b0;

    // 1: reset state, then a ready entry issues the cycle after dispatch
    #12;
    chk("rst.count", 64'(count), 64'd0);
    chk("rst.full", 64'(full), 64'd0);
    chk("rst.issue_en", 64'(issue_en), 64'd0);
    chk("rst.issue_entry", 64'(issue_entry), 64'd0);
    rst = 1'b0;
    alu_ready = 1'b1;
    dispatch_entry = mk(0, 10, 1, 1'b1, 2, 1'b1, 1'b0);
    dispatch_en = 1'b1;
    #1;
    chk("t1.no_issue_in_dispatch_cycle", 64'(issue_en), 64'd0);
    tick();
    dispatch_en = 1'b0;
    chk("t1.count1", 64'(count), 64'd1);
    chk_issue("t1", 0);
    chk("t1.prd", 64'(issue_entry.prd), 64'd10);
    tick();
    chk("t1.count0", 64'(count), 64'd0);
    chk("t1.idle", 64'(issue_en), 64'd0);
    chk("t1.idle_entry", 64'(issue_entry), 64'd0);

    // 2: wait on prs1 via wb0, then on prs2 via wb1
    disp(mk(4, 11, 20, 1'b0, 3, 1'b1, 1'b0));
    for (int i = 0; i < 3; i++) begin
      chk("t2.wait1", 64'(issue_en), 64'd0);
      tick();
    end
    wb0_en = 1'b1; wb0_prd = 6'd20;
    #1;
    chk("t2.no_issue_before_wb_edge", 64'(issue_en), 64'd0);
    tick();
    wb0_en = 1'b0; wb0_prd = '0;
    chk_issue("t2.wb0", 4);
    tick();
    chk("t2.count_a", 64'(count), 64'd0);
    disp(mk(5, 12, 3, 1'b1, 21, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++) begin
      chk("t2.wait2", 64'(issue_en), 64'd0);
      tick();
    end
    wb1_en = 1'b1; wb1_prd = 6'd21;
    tick();
    wb1_en = 1'b0; wb1_prd = '0;
    chk_issue("t2.wb1", 5);
    tick();
    chk("t2.count_b", 64'(count), 64'd0);

    // 3: younger ready entries bypass an older waiting one
    alu_ready = 1'b0;
    disp(mk(1, 13, 30, 1'b0, 4, 1'b1, 1'b0));
    disp(mk(2, 14, 4, 1'b1, 5, 1'b1, 1'b0));
    disp(mk(3, 15, 5, 1'b1, 6, 1'b1, 1'b0));
    chk("t3.count3", 64'(count), 64'd3);
    alu_ready = 1'b1;
    #1;
    chk_issue("t3.first", 2);
    tick();
    chk_issue("t3.second", 3);
    tick();
    chk("t3.count1", 64'(count), 64'd1);
    chk("t3.a_waits", 64'(issue_en), 64'd0);
    wb0_en = 1'b1; wb0_prd = 6'd30;
    tick();
    wb0_en = 1'b0; wb0_prd = '0;
    chk_issue("t3.third", 1);
    tick();
    chk("t3.count0", 64'(count), 64'd0);

    // 4: fill, drop a 9th dispatch, then drain in order
    alu_ready = 1'b0;
    for (int k = 0; k < 8; k++) disp(mk(8 + k, 16 + k, 1, 1'b1, 2, 1'b1, 1'b0));
    chk("t4.full", 64'(full), 64'd1);
    chk("t4.count8", 64'(count), 64'd8);
    disp(mk(16, 40, 1, 1'b1, 2, 1'b1, 1'b0));
    chk("t4.count_after_drop", 64'(count), 64'd8);
    alu_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk_issue("t4.drain", 8 + k);
      tick();
      if (k == 0) chk("t4.full_clear", 64'(full), 64'd0);
    end
    chk("t4.count0", 64'(count), 64'd0);
    chk("t4.no_ninth", 64'(issue_en), 64'd0);

    // 5: insert-time wakeup bypass, and alu_src entry dispatched during an issue
    wb1_en = 1'b1; wb1_prd = 6'd40;
    disp(mk(20, 17, 40, 1'b0, 2, 1'b1, 1'b0));
    wb1_en = 1'b0; wb1_prd = '0;
    chk_issue("t5.bypass", 20);
    disp(mk(21, 18, 1, 1'b1, 50, 1'b0, 1'b1));
    chk("t5.count_after_overlap", 64'(count), 64'd1);
    chk_issue("t5.imm", 21);
    tick();
    chk("t5.count0", 64'(count), 64'd0);

    // 6: flush with a simultaneous dispatch, then asynchronous reset mid-queue
    alu_ready = 1'b0;
    for (int k = 0; k < 5; k++) disp(mk(22 + k, 20 + k, 1, 1'b1, 2, 1'b1, 1'b0));
    chk("t6.count5", 64'(count), 64'd5);
    alu_ready = 1'b1;
    flush = 1'b1;
    dispatch_en = 1'b1;
    dispatch_entry = mk(30, 31, 1, 1'b1, 2, 1'b1, 1'b0);
    #1;
    chk("t6.no_issue_in_flush", 64'(issue_en), 64'd0);
    tick();
    flush = 1'b0;
    dispatch_en = 1'b0;
    dispatch_entry = '0;
    chk("t6.count_after_flush", 64'(count), 64'd0);
    chk("t6.issue_after_flush", 64'(issue_en), 64'd0);
    tick();
    chk("t6.quiet", 64'(issue_en), 64'd0);
    chk("t6.dropped", 64'(count), 64'd0);

    alu_ready = 1'b0;
    for (int k = 0; k < 3; k++) disp(mk(1 + k, 5, 1, 1'b1, 2, 1'b1, 1'b0));
    chk("t6.count3", 64'(count), 64'd3);
    #3;
    rst = 1'b1;
    #1;
    chk("t6.async_count", 64'(count), 64'd0);
    chk("t6.async_full", 64'(full), 64'd0);
    alu_ready = 1'b1;
    #1;
    chk("t6.async_issue", 64'(issue_en), 64'd0);
    chk("t6.async_entry", 64'(issue_entry), 64'd0);
    #10;
    rst = 1'b0;
    tick();
    chk("t6.post_rst_issue", 64'(issue_en), 64'd0);
    chk("t6.post_rst_count", 64'(count), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
